// File: rtl/switcher_pkg.sv
// switcher_pkg: shared types and constants for the switcher_array activity generator.
//   state_t : run-control FSM states
//   mode_t  : bank data-pattern selection (matches the cfg_mode encoding)
//   LFSR_SEED / LFSR_TAPS and lfsr_step(): the shared 32-bit Fibonacci LFSR
package switcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        BURST,
        GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_TOGGLE,
        MODE_ONES,
        MODE_LFSR,
        MODE_WALK
    } mode_t;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    // Taps 32,22,2,1 expressed as bit indices 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Shift left, feedback (XOR of the tapped bits) enters at bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/switcher_if.sv
// switcher_if: control/status bus of switcher_array.
//   master modport : controller side (drives config, start, stop; reads status)
//   slave modport  : switcher_array side
//   cfg_*          : config write (cfg_valid/cfg_ready), mode, channel mask, burst/idle length,
//                    repeat count
//   start/stop     : run control
//   busy/burst_active/done/aborted/burst_cnt/bank_parity : status
interface switcher_if #(
    parameter int unsigned N_CHAN = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned REP_W  = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_mode;
    logic [N_CHAN-1:0] cfg_chan_mask;
    logic [CNT_W-1:0]  cfg_burst_len;
    logic [CNT_W-1:0]  cfg_idle_len;
    logic [REP_W-1:0]  cfg_repeat;
    logic              start;
    logic              stop;
    logic              busy;
    logic              burst_active;
    logic              done;
    logic              aborted;
    logic [REP_W-1:0]  burst_cnt;
    logic [N_CHAN-1:0] bank_parity;

    modport master (
        output cfg_valid, cfg_mode, cfg_chan_mask, cfg_burst_len, cfg_idle_len, cfg_repeat,
        output start, stop,
        input  cfg_ready, busy, burst_active, done, aborted, burst_cnt, bank_parity
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_chan_mask, cfg_burst_len, cfg_idle_len, cfg_repeat,
        input  start, stop,
        output cfg_ready, busy, burst_active, done, aborted, burst_cnt, bank_parity
    );

endinterface

// File: rtl/switcher_bank.sv
// switcher_bank: one REG_SIZE-flop bank of switching activity.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : load the pattern this cycle (BURST, channel enabled, no stop); else load 0
//   mode       : pattern select
//   phase      : TOGGLE phase (0 = all ones) for the current burst cycle
//   idx        : burst cycle index modulo REG_SIZE, for WALK
//   lfsr       : shared LFSR value for the current burst cycle
//   parity     : registered XOR-reduce of the bank (lags the bank by one cycle)
module switcher_bank
    import switcher_pkg::*;
#(
    parameter int unsigned REG_SIZE = 64,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned CHAN     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  mode_t            mode,
    input  logic             phase,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      lfsr,
    output logic             parity
);

    localparam int unsigned WALK_OFS = CHAN % REG_SIZE;
    localparam int unsigned ROT      = (4 * CHAN) % 32;

    logic [REG_SIZE-1:0] bank_q;
    logic [REG_SIZE-1:0] pattern;
    logic                parity_q;
    logic [63:0]         lfsr_dbl;
    logic [31:0]         lfsr_rot;
    logic [IDX_W:0]      walk_sum;

    // Rotate left by ROT: take a 32-bit window out of the doubled word.
    assign lfsr_dbl = {lfsr, lfsr};
    assign lfsr_rot = lfsr_dbl[63-ROT -: 32];

    // (idx + CHAN) mod REG_SIZE without a divider; both terms are already < REG_SIZE.
    always_comb begin
        walk_sum = {1'b0, idx} + (IDX_W+1)'(WALK_OFS);
        if (walk_sum >= (IDX_W+1)'(REG_SIZE)) begin
            walk_sum = walk_sum - (IDX_W+1)'(REG_SIZE);
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_TOGGLE: pattern = phase ? '0 : '1;
            MODE_ONES:   pattern = '1;
            MODE_LFSR: begin
                for (int i = 0; i < int'(REG_SIZE); i++) begin
                    pattern[i] = lfsr_rot[i % 32];
                end
            end
            MODE_WALK: begin
                for (int i = 0; i < int'(REG_SIZE); i++) begin
                    pattern[i] = (walk_sum == (IDX_W+1)'(i));
                end
            end
            default: pattern = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            bank_q   <= en ? pattern : '0;
            parity_q <= ^bank_q;
        end
    end

    assign parity = parity_q;

endmodule

// File: rtl/switcher_array.sv
// switcher_array: programmable multi-channel switching-activity generator. Runs timed bursts of
// pattern data on N_CHAN banks of REG_SIZE flops, separated by idle gaps, for a set number of
// bursts or until stopped.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : switcher_if slave (config write, start/stop, status, bank parity)
module switcher_array
    import switcher_pkg::*;
#(
    parameter int unsigned N_CHAN   = 4,
    parameter int unsigned REG_SIZE = 64,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned REP_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    switcher_if.slave  bus
);

    localparam int unsigned IDX_W = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;

    state_t            state_q, state_d;
    mode_t             mode_q;
    logic [N_CHAN-1:0] mask_q;
    logic [CNT_W-1:0]  burst_len_q, idle_len_q;
    logic [REP_W-1:0]  repeat_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              aborted_q, aborted_d;

    logic              cfg_load;
    logic              bank_en;
    logic              last_burst;
    logic [CNT_W-1:0]  burst_reload;
    logic [REP_W-1:0]  burst_cnt_inc;
    logic [IDX_W-1:0]  idx_next;
    logic [N_CHAN-1:0] parity;

    assign cfg_load = bus.cfg_valid && (state_q == IDLE);

    // A zero burst length still produces a one-cycle burst.
    assign burst_reload  = (burst_len_q == '0) ? '0 : burst_len_q - CNT_W'(1);
    assign burst_cnt_inc = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + REP_W'(1);
    assign last_burst    = (repeat_q != '0) &&
                           (({1'b0, burst_cnt_q} + (REP_W+1)'(1)) == {1'b0, repeat_q});
    assign idx_next      = (idx_q == IDX_W'(REG_SIZE - 1)) ? '0 : idx_q + IDX_W'(1);

    // Banks clear on the same edge that stop is seen.
    assign bank_en = (state_q == BURST) && !bus.stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_TOGGLE;
            mask_q      <= '0;
            burst_len_q <= '0;
            idle_len_q  <= '0;
            repeat_q    <= '0;
        end else if (cfg_load) begin
            mode_q      <= mode_t'(bus.cfg_mode);
            mask_q      <= bus.cfg_chan_mask;
            burst_len_q <= bus.cfg_burst_len;
            idle_len_q  <= bus.cfg_idle_len;
            repeat_q    <= bus.cfg_repeat;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_cnt_d = burst_cnt_q;
        lfsr_d      = lfsr_q;
        aborted_d   = aborted_q;
        // Pattern position is zero outside a burst, so every burst starts at k = 0.
        phase_d     = 1'b0;
        idx_d       = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = ARM;
                end
            end

            ARM: begin
                cnt_d       = burst_reload;
                burst_cnt_d = '0;
                lfsr_d      = LFSR_SEED;
                aborted_d   = 1'b0;
                state_d     = BURST;
                if (bus.stop) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end

            BURST: begin
                lfsr_d  = lfsr_step(lfsr_q);
                phase_d = ~phase_q;
                idx_d   = idx_next;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    burst_cnt_d = burst_cnt_inc;
                    phase_d     = 1'b0;
                    idx_d       = '0;
                    if (last_burst) begin
                        state_d = DONE;
                    end else if (idle_len_q != '0) begin
                        state_d = GAP;
                        cnt_d   = idle_len_q - CNT_W'(1);
                    end else begin
                        cnt_d = burst_reload;
                    end
                end
                // Stop wins, but a burst ending this cycle has already been counted above.
                if (bus.stop) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end

            GAP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = BURST;
                    cnt_d   = burst_reload;
                end
                if (bus.stop) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            burst_cnt_q <= '0;
            lfsr_q      <= '0;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_cnt_q <= burst_cnt_d;
            lfsr_q      <= lfsr_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            aborted_q   <= aborted_d;
        end
    end

    for (genvar c = 0; c < int'(N_CHAN); c++) begin : g_bank
        switcher_bank #(
            .REG_SIZE (REG_SIZE),
            .IDX_W    (IDX_W),
            .CHAN     (c)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bank_en && mask_q[c]),
            .mode   (mode_q),
            .phase  (phase_q),
            .idx    (idx_q),
            .lfsr   (lfsr_q),
            .parity (parity[c])
        );
    end

    assign bus.cfg_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q == ARM) || (state_q == BURST) ||
                              (state_q == GAP) || (state_q == DONE);
    assign bus.burst_active = (state_q == BURST);
    assign bus.done         = (state_q == DONE);
    assign bus.aborted      = (state_q == DONE) && aborted_q;
    assign bus.burst_cnt    = burst_cnt_q;
    assign bus.bank_parity  = parity;

endmodule

// File: tb/tb_switcher_array.sv
// tb_switcher_array: directed self-checking bench for switcher_array (N_CHAN=4, REG_SIZE=64).
module tb_switcher_array;
    import switcher_pkg::*;

    localparam logic [63:0] ALL1 = {64{1'b1}};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    switcher_if #(.N_CHAN(4), .CNT_W(16), .REP_W(8)) bus ();

    switcher_array #(
        .N_CHAN   (4),
        .REG_SIZE (64),
        .CNT_W    (16),
        .REP_W    (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] bank0, bank1, bank2, bank3;
    assign bank0 = u_dut.g_bank[0].u_bank.bank_q;
    assign bank1 = u_dut.g_bank[1].u_bank.bank_q;
    assign bank2 = u_dut.g_bank[2].u_bank.bank_q;
    assign bank3 = u_dut.g_bank[3].u_bank.bank_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input mode_t mode, input logic [3:0] mask, input logic [15:0] bl,
                             input logic [15:0] il, input logic [7:0] rep);
        bus.cfg_mode      = mode;
        bus.cfg_chan_mask = mask;
        bus.cfg_burst_len = bl;
        bus.cfg_idle_len  = il;
        bus.cfg_repeat    = rep;
        bus.cfg_valid     = 1'b1;
        tick();
        bus.cfg_valid     = 1'b0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts burst_active cycles until done; -1 if done never arrives.
    task automatic count_burst(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) return;
            if (bus.burst_active) n++;
            tick();
        end
        n = -1;
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    initial begin
        logic [31:0] lref;
        logic [31:0] lrot;
        logic [63:0] exp_v;
        int          n;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_mode = 2'd0;
        bus.cfg_chan_mask = '0;
        bus.cfg_burst_len = '0;
        bus.cfg_idle_len = '0;
        bus.cfg_repeat = '0;
        bus.start = 1'b0;
        bus.stop = 1'b0;

        #3;
        check_eq("rst_ready", bus.cfg_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_cnt", bus.burst_cnt, 0);
        check_eq("rst_bank0", bank0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // TOGGLE, banks 0 and 2 enabled, 3 bursts of 4 with 2-cycle gaps.
        write_cfg(MODE_TOGGLE, 4'b0101, 16'd4, 16'd2, 8'd3);
        start_run();
        check_eq("tog_arm_busy", bus.busy, 1);
        check_eq("tog_arm_act", bus.burst_active, 0);
        check_eq("tog_arm_ready", bus.cfg_ready, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                check_eq("tog_active", bus.burst_active, 1);
                tick();
                exp_v = (k % 2 == 0) ? ALL1 : 64'd0;
                check_eq("tog_bank0", bank0, exp_v);
                check_eq("tog_bank1", bank1, 0);
                check_eq("tog_bank2", bank2, exp_v);
                check_eq("tog_bank3", bank3, 0);
            end
            if (b < 2) begin
                check_eq("tog_gap_act", bus.burst_active, 0);
                check_eq("tog_gap_cnt", bus.burst_cnt, 64'(b + 1));
                tick();
                check_eq("tog_gap_bank0", bank0, 0);
                tick();
            end
        end
        check_eq("tog_done", bus.done, 1);
        check_eq("tog_aborted", bus.aborted, 0);
        check_eq("tog_cnt", bus.burst_cnt, 3);
        tick();
        check_eq("tog_idle_done", bus.done, 0);
        check_eq("tog_idle_busy", bus.busy, 0);
        check_eq("tog_idle_ready", bus.cfg_ready, 1);
        check_eq("tog_idle_bank0", bank0, 0);

        // ONES, zero lengths: two one-cycle bursts back to back.
        write_cfg(MODE_ONES, 4'b1111, 16'd0, 16'd0, 8'd2);
        start_run();
        tick();
        check_eq("ones_act0", bus.burst_active, 1);
        tick();
        check_eq("ones_act1", bus.burst_active, 1);
        check_eq("ones_bank3", bank3, ALL1);
        check_eq("ones_cnt1", bus.burst_cnt, 1);
        tick();
        check_eq("ones_done", bus.done, 1);
        check_eq("ones_act_end", bus.burst_active, 0);
        check_eq("ones_cnt", bus.burst_cnt, 2);
        check_eq("ones_aborted", bus.aborted, 0);
        tick();

        // LFSR, infinite repeat, stop on cycle 5 of the second burst.
        write_cfg(MODE_LFSR, 4'b0011, 16'd8, 16'd2, 8'd0);
        start_run();
        tick();
        lref = 32'hACE1_0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            lrot = {lref[27:0], lref[31:28]};
            check_eq("lfsr_b1_bank0", bank0, {lref, lref});
            check_eq("lfsr_b1_bank1", bank1, {lrot, lrot});
            lref = ref_step(lref);
        end
        check_eq("lfsr_gap_act", bus.burst_active, 0);
        check_eq("lfsr_gap_cnt", bus.burst_cnt, 1);
        tick();
        check_eq("lfsr_gap_bank0", bank0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            lrot = {lref[27:0], lref[31:28]};
            check_eq("lfsr_b2_bank0", bank0, {lref, lref});
            check_eq("lfsr_b2_bank1", bank1, {lrot, lrot});
            lref = ref_step(lref);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("lfsr_done", bus.done, 1);
        check_eq("lfsr_aborted", bus.aborted, 1);
        check_eq("lfsr_cnt", bus.burst_cnt, 1);
        check_eq("lfsr_stop_bank0", bank0, 0);
        tick();
        check_eq("lfsr_idle_busy", bus.busy, 0);

        // WALK, 70-cycle burst wraps past bit 63.
        write_cfg(MODE_WALK, 4'b0011, 16'd70, 16'd0, 8'd1);
        start_run();
        tick();
        for (int k = 0; k < 70; k++) begin
            tick();
            check_eq("walk_bank0", bank0, 64'd1 << (k % 64));
            check_eq("walk_bank1", bank1, 64'd1 << ((k + 1) % 64));
            if (k == 5) check_eq("walk_parity", bus.bank_parity, 4'b0011);
        end
        check_eq("walk_done", bus.done, 1);
        check_eq("walk_cnt", bus.burst_cnt, 1);
        tick();

        // Config write while busy is ignored.
        write_cfg(MODE_ONES, 4'b0001, 16'd4, 16'd0, 8'd1);
        start_run();
        bus.cfg_burst_len = 16'd99;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        count_burst(n);
        check_eq("busy_cfg_len", n, 4);
        tick();

        // Config write with start in IDLE uses the new burst length.
        bus.cfg_burst_len = 16'd3;
        bus.cfg_valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.start = 1'b0;
        tick();
        count_burst(n);
        check_eq("cfg_start_len", n, 3);
        tick();

        // start with stop in IDLE stays IDLE.
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check_eq("ss_busy", bus.busy, 0);
        check_eq("ss_ready", bus.cfg_ready, 1);
        tick();
        check_eq("ss_busy2", bus.busy, 0);

        // Reset in the middle of a burst.
        write_cfg(MODE_ONES, 4'b1111, 16'd10, 16'd0, 8'd0);
        start_run();
        tick();
        tick();
        tick();
        check_eq("mid_bank2_pre", bank2, ALL1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_bank2", bank2, 0);
        check_eq("mid_busy", bus.busy, 0);
        check_eq("mid_cnt", bus.burst_cnt, 0);
        check_eq("mid_ready", bus.cfg_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mid_done", bus.done, 0);
        end
        rst_n = 1'b1;
        tick();
        check_eq("mid_post_done", bus.done, 0);
        check_eq("mid_post_busy", bus.busy, 0);
        check_eq("mid_post_ready", bus.cfg_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switcher_array.md
Name: switcher_array

Overview:
- Programmable multi-channel switching-activity generator for ring-oscillator side-channel characterisation.
- Drives N_CHAN banks of REG_SIZE flops with selectable data patterns in timed bursts separated by idle gaps. Bursts repeat a set number of times or run until stopped.
- Sits beside the ring-oscillator sampler under the same control bus. It is the parametrised successor to the fixed single-bank toggler.

Parameters:
- N_CHAN, 4: number of independent register banks.
- REG_SIZE, 64: flops per bank.
- CNT_W, 16: width of the burst-length and idle-length counters.
- REP_W, 8: width of the repeat counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write strobe.
- cfg_ready  out  1  high only in IDLE.
- cfg_mode  in  2  pattern: 0 TOGGLE, 1 ONES, 2 LFSR, 3 WALK.
- cfg_chan_mask  in  N_CHAN  channel enables.
- cfg_burst_len  in  CNT_W  active cycles per burst.
- cfg_idle_len  in  CNT_W  gap cycles between bursts.
- cfg_repeat  in  REP_W  bursts per run; 0 means infinite.
- start  in  1  begin run (level sampled).
- stop  in  1  abort run.
- busy  out  1  run in progress.
- burst_active  out  1  high during BURST.
- done  out  1  one-cycle pulse at end of run.
- aborted  out  1  qualifies done; 1 if the run ended by stop.
- burst_cnt  out  REP_W  bursts completed in the current or last run.
- bank_parity  out  N_CHAN  XOR-reduce of each bank; keeps the banks from being trimmed.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all banks, counters and LFSR cleared; all outputs 0 except cfg_ready=1. Reset mid-run abandons the run with no done pulse.
- Config registers load on cfg_valid && cfg_ready. Writes outside IDLE are ignored.
- States and transitions:
  - IDLE: start && !stop → ARM. If cfg_valid and start occur in the same cycle, the run uses the new config. start outside IDLE is ignored.
  - ARM (1 cycle): load burst counter = max(burst_len,1)-1; clear burst_cnt; seed LFSR = 32'hACE1_0001; clear banks; busy=1. Next state is BURST.
  - BURST: burst_active=1. Masked-on banks update every cycle per mode; masked-off banks hold 0.
    - Counter reaches 0: burst_cnt increments (saturating).
    - If cfg_repeat != 0 and burst_cnt+1 == cfg_repeat → DONE.
    - Otherwise → GAP when idle_len != 0, or straight back to BURST (counter reloaded) when idle_len == 0.
  - GAP: banks forced to 0. Counter starts at idle_len-1 and decrements; at 0 → BURST with counter reloaded.
  - DONE (1 cycle): done=1; banks 0. Next state is IDLE, where busy=0.
- stop in ARM, BURST or GAP: next state is DONE with aborted=1, and banks are 0 from the next cycle. stop has priority over every other transition, including a normal burst end in the same cycle; that burst still counts.
- Pattern modes (value written at each BURST cycle k, k=0 first):
  - TOGGLE: all ones when k is even, zeros when k is odd.
  - ONES: all ones, held constant (static baseline).
  - LFSR: 32-bit Fibonacci LFSR, taps 32,22,2,1, steps once per BURST cycle. Bank c = the LFSR value rotated left by 4*c, replicated and truncated to REG_SIZE.
  - WALK: one-hot; bank c holds bit ((k+c) mod REG_SIZE).
- Pattern state resets to k=0 at the start of every burst. The LFSR is not reseeded between bursts.
- Latency: start high in IDLE → ARM next cycle → first pattern value on the banks 2 cycles after start is sampled.
- bank_parity is registered from the banks; it lags the banks by 1 cycle.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Package switcher_pkg holds:
  - state_t {IDLE, ARM, BURST, GAP, DONE};
  - mode_t {MODE_TOGGLE, MODE_ONES, MODE_LFSR, MODE_WALK};
  - LFSR_SEED and LFSR_TAPS constants.
- One sub-module, switcher_bank: a single bank with pattern generation per mode, mask gating and parity. It is instantiated N_CHAN times from a generate loop.
- Top level holds the FSM, the counters and the shared LFSR.

Test Plan:
- Reset mid-BURST (rst_n low for 3 cycles) → banks, busy, burst_cnt = 0 immediately; no done pulse; cfg_ready=1.
- TOGGLE, mask=4'b0101, burst_len=4, idle_len=2, repeat=3:
  - banks 0 and 2 read FF..,00..,FF..,00.. during each burst; banks 1 and 3 stay 0.
  - 3 bursts, with gaps of 2 cycles;
  - done after 4+2+4+2+4 BURST/GAP cycles; burst_cnt=3; aborted=0.
- burst_len=0, idle_len=0, repeat=2, ONES → 2 one-cycle bursts back-to-back; burst_active high for 2 cycles; done, burst_cnt=2.
- LFSR mode, burst_len=8, repeat=0; stop asserted on cycle 5 of the 2nd burst:
  - bank 0 matches the reference LFSR sequence from seed ACE10001;
  - DONE next cycle with aborted=1, burst_cnt=1.
- WALK, REG_SIZE=64, burst_len=70 → bank 1 is one-hot at bit (k+1) mod 64 and wraps correctly at k=63.
- cfg_valid while busy (burst_len=99) → ignored. cfg_valid together with start in IDLE → the new burst_len is used. start and stop in the same cycle in IDLE → stays IDLE.
